// File: rtl/cpu_pkg.sv
// Shared types for the pipeline sequencing controller.
//   hazard_state_e : controller states
//   pipe_ctrl_t    : the eight pipeline enable/flush/inhibit controls
//   CTRL_*         : control words for each pipeline situation
//   load_use()     : load-use hazard detection term
package cpu_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        RUN        = 3'd1,
        LOAD_STALL = 3'd2,
        BR_FLUSH   = 3'd3,
        MEM_WAIT   = 3'd4
    } hazard_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic inhibit_control;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    // Held in reset/first cycle: nothing advances, decoder emits zero controls.
    localparam pipe_ctrl_t CTRL_INIT = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b0, id_ex_flush: 1'b0, inhibit_control: 1'b1,
                                         ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};
    // Normal flow: every stage advances.
    localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                        id_ex_write: 1'b1, id_ex_flush: 1'b0, inhibit_control: 1'b0,
                                        ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
    // Load-use: freeze PC and IF/ID, let a zero control word enter ID/EX.
    localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                          id_ex_write: 1'b1, id_ex_flush: 1'b0, inhibit_control: 1'b1,
                                          ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
    // Taken branch: fetch the target while squashing the wrong-path work.
    localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                          id_ex_write: 1'b1, id_ex_flush: 1'b1, inhibit_control: 1'b1,
                                          ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
    // Data memory busy: everything up to EX/MEM holds, WB sees a bubble.
    localparam pipe_ctrl_t CTRL_MWAIT = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                          id_ex_write: 1'b0, id_ex_flush: 1'b0, inhibit_control: 1'b0,
                                          ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

    // A load in EX whose destination (not x0) is read by the instruction in ID.
    function automatic logic load_use(input logic       ex_mem_read,
                                      input logic [4:0] ex_rd,
                                      input logic [4:0] id_rs1,
                                      input logic [4:0] id_rs2,
                                      input logic       id_uses_rs2);
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on each clock with inc_i=1, sticks at all-ones.
// Ports: clk_i, rst_ni (async active-low clear), inc_i, count_o[W-1:0].
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
// Inputs : ID source registers, EX destination/load flag, EX branch resolution,
//          MEM-stage data-memory request/ready handshake.
// Outputs: pipeline register write/flush controls, decoder inhibit, sticky
//          memory-timeout flag, saturating stall-cycle and flush-event counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 256,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_flush_o,
    output logic             inhibit_control_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LIMIT  = WT_W'(MEM_TIMEOUT);

    hazard_state_e   state_q, state_d, eff_state_s;
    logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;
    pipe_ctrl_t      ctrl_s;
    logic            lu_s, mw_s, stall_inc_s, flush_inc_s;

    assign lu_s = load_use(ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);
    assign mw_s = dmem_req_i & ~dmem_ready_i;

    // When a memory wait ends, resume whatever it interrupted: an unfinished
    // branch flush (frozen countdown still nonzero) or normal running.
    always_comb begin
        if (state_q == MEM_WAIT) begin
            eff_state_s = (flush_cnt_q != '0) ? BR_FLUSH : RUN;
        end else begin
            eff_state_s = state_q;
        end
    end

    // Next state, flush countdown and pipeline controls; priority mw > branch > lu.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ctrl_s      = CTRL_RUN;
        flush_inc_s = 1'b0;
        if (state_q == INIT) begin
            ctrl_s  = CTRL_INIT;
            state_d = RUN;
        end else if (mw_s) begin
            // Countdown is left untouched so a flush in progress resumes later.
            ctrl_s  = CTRL_MWAIT;
            state_d = MEM_WAIT;
        end else if (branch_taken_i) begin
            ctrl_s      = CTRL_FLUSH;
            flush_inc_s = 1'b1;
            flush_cnt_d = FC_RELOAD;
            state_d     = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
        end else begin
            case (eff_state_s)
                BR_FLUSH: begin
                    ctrl_s = CTRL_FLUSH;
                    if (flush_cnt_q > FC_W'(1)) begin
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                        state_d     = BR_FLUSH;
                    end else begin
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (lu_s) begin
                        ctrl_s  = CTRL_STALL;
                        state_d = LOAD_STALL;
                    end else begin
                        ctrl_s  = CTRL_RUN;
                        state_d = RUN;
                    end
                end
                // LOAD_STALL: the bubble is already in EX, so a repeated lu is ignored.
                default: begin
                    ctrl_s  = CTRL_RUN;
                    state_d = RUN;
                end
            endcase
        end
    end

    // Memory-wait cycle counter and sticky timeout flag.
    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if ((state_q == MEM_WAIT) && mw_s) begin
            if (wait_cnt_q != WT_LIMIT) begin
                wait_cnt_d = wait_cnt_q + WT_W'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
            if ((MEM_TIMEOUT != 0) && ((wait_cnt_q + WT_W'(1)) == WT_LIMIT)) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            wait_cnt_d = '0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_inc_s = (state_q != INIT) & ~ctrl_s.pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (stall_inc_s),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (flush_inc_s),
        .count_o (flush_events_o)
    );

    assign pc_write_o        = ctrl_s.pc_write;
    assign if_id_write_o     = ctrl_s.if_id_write;
    assign if_id_flush_o     = ctrl_s.if_id_flush;
    assign id_ex_write_o     = ctrl_s.id_ex_write;
    assign id_ex_flush_o     = ctrl_s.id_ex_flush;
    assign inhibit_control_o = ctrl_s.inhibit_control;
    assign ex_mem_write_o    = ctrl_s.ex_mem_write;
    assign mem_wb_bubble_o   = ctrl_s.mem_wb_bubble;
    assign mem_timeout_o     = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances with different parameters share one
// stimulus stream; a cycle-level reference model tracks remaining flush
// cycles, wait length and the one-shot load-use stall.
module tb_hazard_ctrl;

    localparam int FC0 = 2, MT0 = 8, CW0 = 4;
    localparam int FC1 = 3, MT1 = 0, CW1 = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       uses2, exmr, br, req, rdy;

    wire  [7:0] ctl0, ctl1;
    wire  [3:0] st0, fe0;
    wire  [7:0] st1, fe1;
    wire        to0, to1;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    bit m_init  [2];
    int m_fl    [2];
    bit m_wait  [2];
    int m_wc    [2];
    bit m_lud   [2];
    bit m_to    [2];
    int m_stall [2];
    int m_flush [2];

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.FLUSH_CYCLES(FC0), .MEM_TIMEOUT(MT0), .CNT_W(CW0)) u0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs2_i(uses2), .ex_rd_i(ex_rd), .ex_mem_read_i(exmr), .branch_taken_i(br),
        .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(ctl0[7]), .if_id_write_o(ctl0[6]), .if_id_flush_o(ctl0[5]),
        .id_ex_write_o(ctl0[4]), .id_ex_flush_o(ctl0[3]), .inhibit_control_o(ctl0[2]),
        .ex_mem_write_o(ctl0[1]), .mem_wb_bubble_o(ctl0[0]),
        .mem_timeout_o(to0), .stall_cycles_o(st0), .flush_events_o(fe0));

    hazard_ctrl #(.FLUSH_CYCLES(FC1), .MEM_TIMEOUT(MT1), .CNT_W(CW1)) u1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs2_i(uses2), .ex_rd_i(ex_rd), .ex_mem_read_i(exmr), .branch_taken_i(br),
        .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(ctl1[7]), .if_id_write_o(ctl1[6]), .if_id_flush_o(ctl1[5]),
        .id_ex_write_o(ctl1[4]), .id_ex_flush_o(ctl1[3]), .inhibit_control_o(ctl1[2]),
        .ex_mem_write_o(ctl1[1]), .mem_wb_bubble_o(ctl1[0]),
        .mem_timeout_o(to1), .stall_cycles_o(st1), .flush_events_o(fe1));

    function automatic int fc_of(int k); return (k == 0) ? FC0 : FC1; endfunction
    function automatic int mt_of(int k); return (k == 0) ? MT0 : MT1; endfunction
    function automatic int max_of(int k); return (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1); endfunction

    function automatic logic [7:0] obs_ctl(int k);   return (k == 0) ? ctl0 : ctl1; endfunction
    function automatic int         obs_stall(int k); return (k == 0) ? int'(st0) : int'(st1); endfunction
    function automatic int         obs_flush(int k); return (k == 0) ? int'(fe0) : int'(fe1); endfunction
    function automatic bit         obs_to(int k);    return (k == 0) ? to0 : to1; endfunction

    function automatic bit lu_now();
        return exmr && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (uses2 && (ex_rd == id_rs2)));
    endfunction

    // Expected control vector {pc, ifid_w, ifid_f, idex_w, idex_f, inhibit, exmem_w, bubble}.
    function automatic logic [7:0] exp_ctrl(int k);
        if (m_init[k])              return 8'b0000_0101;
        if (req && !rdy)            return 8'b0000_0001;
        if (br || (m_fl[k] > 0))    return 8'b1111_1110;
        if (lu_now() && !m_lud[k])  return 8'b0001_0110;
        return 8'b1101_0010;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_init[k] = 1'b1; m_fl[k] = 0; m_wait[k] = 1'b0; m_wc[k] = 0;
            m_lud[k] = 1'b0; m_to[k] = 1'b0; m_stall[k] = 0; m_flush[k] = 0;
        end
    endtask

    // Advance the model by one clock edge given the controls it expected.
    task automatic model_clock(int k, logic [7:0] e);
        if (m_init[k]) begin
            m_init[k] = 1'b0;
        end else begin
            if (!e[7] && (m_stall[k] < max_of(k))) m_stall[k]++;
            if (req && !rdy) begin
                if (m_wait[k]) begin
                    m_wc[k]++;
                    if ((mt_of(k) != 0) && (m_wc[k] == mt_of(k))) m_to[k] = 1'b1;
                end
                m_wait[k] = 1'b1;
                m_lud[k]  = 1'b0;
            end else begin
                m_wait[k] = 1'b0;
                m_wc[k]   = 0;
                if (br) begin
                    if (m_flush[k] < max_of(k)) m_flush[k]++;
                    m_fl[k]  = fc_of(k) - 1;
                    m_lud[k] = 1'b0;
                end else if (m_fl[k] > 0) begin
                    m_fl[k]--;
                    m_lud[k] = 1'b0;
                end else begin
                    m_lud[k] = lu_now() && !m_lud[k];
                end
            end
        end
    endtask

    task automatic check_inst(int k, string tag);
        logic [7:0] e;
        e = exp_ctrl(k);
        checks++;
        assert (obs_ctl(k) === e) else begin
            errors++; $error("FAIL %s u%0d ctrl got %b exp %b", tag, k, obs_ctl(k), e);
        end
        checks++;
        assert (obs_stall(k) === m_stall[k]) else begin
            errors++; $error("FAIL %s u%0d stall_cycles got %0d exp %0d", tag, k, obs_stall(k), m_stall[k]);
        end
        checks++;
        assert (obs_flush(k) === m_flush[k]) else begin
            errors++; $error("FAIL %s u%0d flush_events got %0d exp %0d", tag, k, obs_flush(k), m_flush[k]);
        end
        checks++;
        assert (obs_to(k) === m_to[k]) else begin
            errors++; $error("FAIL %s u%0d mem_timeout got %0d exp %0d", tag, k, obs_to(k), m_to[k]);
        end
    endtask

    task automatic set_in(logic [4:0] rs1, logic [4:0] rs2, logic u2, logic [4:0] rd,
                          logic mr, logic b, logic rq, logic rd_y);
        id_rs1 = rs1; id_rs2 = rs2; uses2 = u2; ex_rd = rd;
        exmr = mr; br = b; req = rq; rdy = rd_y;
    endtask

    // One clock: check at the falling edge, then step the model past the rising edge.
    task automatic cycle(string tag);
        logic [7:0] e0, e1;
        @(negedge clk_i);
        check_inst(0, tag);
        check_inst(1, tag);
        e0 = exp_ctrl(0);
        e1 = exp_ctrl(1);
        @(posedge clk_i);
        #1;
        model_clock(0, e0);
        model_clock(1, e1);
    endtask

    initial begin
        rst_ni = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_inst(0, "reset"); check_inst(1, "reset");
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cycle("init_cycle");
        cycle("run_idle");

        // Load-use through rs2; held into the stall cycle, where it must be ignored.
        set_in(5'd7, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu_stall");
        cycle("lu_ignored");
        set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu_x0");
        set_in(5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs2_unused");
        set_in(5'd9, 5'd1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu_rs1");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("after_lu");

        // Branch pulse, then branch together with a load-use.
        br = 1'b1;
        cycle("br_pulse");
        br = 1'b0;
        repeat (3) cycle("br_flush_tail");
        set_in(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("br_with_lu");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("br_lu_tail");

        // Back-to-back branches reload the countdown.
        br = 1'b1;
        repeat (2) cycle("br_back2back");
        br = 1'b0;
        repeat (3) cycle("br_b2b_tail");

        // Memory wait with a branch held in EX, flushed on the ready cycle.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle("mw_branch");
        rdy = 1'b1;
        cycle("mw_ready_flush");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("mw_br_tail");

        // Memory wait interrupting a flush countdown.
        br = 1'b1;
        cycle("br_before_mw");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle("mw_freeze");
        rdy = 1'b1;
        cycle("mw_resume");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("resume_tail");

        // Timeout: ready withheld for 10 cycles, flag stays after completion.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cycle("mw_timeout");
        rdy = 1'b1;
        cycle("mw_to_ready");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle("to_sticky");

        // Long stall run drives the 4-bit stall counter into saturation.
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (20) cycle("stall_sat");
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("sat_hold");

        // Asynchronous reset mid-operation.
        br = 1'b1;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_inst(0, "async_reset"); check_inst(1, "async_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        br = 1'b0;
        cycle("post_reset_init");
        cycle("post_reset_run");

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Detects load-use hazards, taken-branch flushes and data-memory wait states.
- Drives the pipeline-register write enables and flushes, and the inhibit input of the instruction decoder, so that bubbles enter ID/EX as all-zero control words.
- Keeps sticky timeout status and saturating performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles the IF/ID and ID/EX flushes stay asserted per taken branch (>=1).
- MEM_TIMEOUT, 256, MEM_WAIT cycles before mem_timeout_o sets; 0 disables the timeout.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- id_rs1_i  in  5  rs1 of instruction in ID
- id_rs2_i  in  5  rs2 of instruction in ID
- id_uses_rs2_i  in  1  ID instruction reads rs2 (R, S, SB types)
- ex_rd_i  in  5  rd of instruction in EX
- ex_mem_read_i  in  1  EX instruction is a load
- branch_taken_i  in  1  EX resolved a taken branch
- dmem_req_i  in  1  MEM stage issuing a load or store
- dmem_ready_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- if_id_write_o  out  1  IF/ID write enable
- if_id_flush_o  out  1  IF/ID clear to NOP
- id_ex_write_o  out  1  ID/EX write enable
- id_ex_flush_o  out  1  ID/EX clear
- inhibit_control_o  out  1  decoder inhibit; forces a zero control word
- ex_mem_write_o  out  1  EX/MEM write enable
- mem_wb_bubble_o  out  1  MEM/WB captures a bubble
- mem_timeout_o  out  1  sticky memory-timeout flag
- stall_cycles_o  out  CNT_W  saturating count of cycles with pc_write_o=0, INIT excluded
- flush_events_o  out  CNT_W  saturating count of taken-branch flush entries

Behaviour:
- States: INIT, RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT.
- Reset (async, rst_ni=0): state INIT; counters 0; mem_timeout_o=0.
- INIT outputs: all write enables 0, flushes 0, inhibit_control_o=1, mem_wb_bubble_o=1.
- INIT -> RUN on the first rising edge with rst_ni=1.
- Default outputs (RUN, no event): all write enables 1, flushes 0, inhibit 0, bubble 0.
- Hazard terms, combinational, same cycle:
  - lu = ex_mem_read_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
  - mw = dmem_req_i & ~dmem_ready_i.
- Priority: mw > branch_taken_i > lu.
- mw (any non-INIT state):
  - pc, if_id, id_ex and ex_mem writes = 0; mem_wb_bubble_o=1; flushes 0.
  - Next state MEM_WAIT. The current BR_FLUSH countdown freezes and resumes after the wait.
- MEM_WAIT:
  - Outputs as for mw while mw holds.
  - On the dmem_ready_i cycle, outputs follow the RUN rules and exit to the state implied by the remaining terms.
  - A branch in EX held through the wait (branch_taken_i still 1) is flushed on exit.
  - Wait counter counts cycles in MEM_WAIT and clears on exit. When it equals MEM_TIMEOUT (nonzero), mem_timeout_o=1 and stays set until reset; the state remains MEM_WAIT.
- branch_taken_i without mw:
  - if_id_flush_o=1, id_ex_flush_o=1, inhibit_control_o=1; pc_write_o=1 to load the target.
  - flush_events_o += 1.
  - FLUSH_CYCLES=1: stay in RUN. Otherwise enter BR_FLUSH with countdown FLUSH_CYCLES-1.
  - Suppresses lu in the same cycle; no stall is counted.
- BR_FLUSH:
  - Flushes and inhibit stay asserted; PC writes continue.
  - Countdown reaches 0 -> RUN.
  - A new branch_taken_i reloads the countdown and counts a new event.
- lu (RUN only):
  - pc_write_o=0, if_id_write_o=0, inhibit_control_o=1, id_ex_write_o=1 (bubble enters EX).
  - Next state LOAD_STALL for exactly one cycle.
  - LOAD_STALL -> RUN unconditionally; lu re-detected there is ignored (bubble already inserted), except mw/branch still apply.
- Counters saturate at all-ones with no wrap. A stalled cycle increments stall_cycles_o on the following edge.
- Reset asserted mid-operation: immediate return to the INIT outputs; counters and the sticky flag clear.

Decomposition:
- cpu_pkg: hazard_state_e enum (INIT, RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT); pipe_ctrl_t struct bundling the eight pipeline enable/flush/inhibit outputs.
- Sub-module sat_counter (parameter W; inputs clk_i, rst_ni, inc_i; output count_o), instantiated for both performance counters.

Test Plan:
- Hold rst_ni=0 for 3 cycles, release -> first cycle INIT outputs (inhibit=1, writes 0); then all writes 1; counters 0.
- ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 for 1 cycle -> pc_write_o=0, inhibit_control_o=1 for exactly 1 cycle; stall_cycles_o=1. Same with ex_rd_i=0 -> no stall.
- FLUSH_CYCLES=2, branch_taken_i pulse -> both flushes high for 2 cycles; flush_events_o=1. Branch and lu in the same cycle -> no stall, flush only.
- dmem_req_i=1, dmem_ready_i=0 for 4 cycles with branch_taken_i=1 -> all writes 0 for 4 cycles; flush asserted on the ready cycle; stall_cycles_o=4.
- MEM_TIMEOUT=8, ready withheld 10 cycles -> mem_timeout_o rises after 8 cycles in MEM_WAIT and stays 1 after ready; clears only on reset.
- CNT_W=4, 20 consecutive stall cycles -> stall_cycles_o saturates at 15.
